// File: rtl/iter_div.sv
`default_nettype none
// iter_div: 32-bit signed/unsigned restoring radix-2 divider, one quotient bit per cycle.
// result = {remainder, quotient}; ready pulses once per completed, non-annulled operation.
module iter_div (
   input  logic        clk,
   input  logic        resetn,
   input  logic        signed_div,
   input  logic [31:0] opdata1,
   input  logic [31:0] opdata2,
   input  logic        start,
   input  logic        annul,
   output logic [63:0] result,
   output logic        ready,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIVZERO = 2'd1,
      S_ON      = 2'd2,
      S_END     = 2'd3
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [5:0]  cnt;
   logic [64:0] part;
   logic [31:0] dsor;
   logic        neg_q;
   logic        neg_r;

   logic        accept;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic        ge;
   logic [31:0] diff;
   logic [64:0] part_step;
   logic [31:0] quo;
   logic [31:0] rem;

   assign accept = start && !annul;
   assign mag1   = (signed_div && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
   assign mag2   = (signed_div && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;

   // part[64:32] is the shifted partial remainder with the next dividend bit appended;
   // when it is >= divisor the difference always fits in 32 bits.
   assign ge        = part[64:32] >= {1'b0, dsor};
   assign diff      = part[63:32] - dsor;
   assign part_step = ge ? {diff, part[31:0], 1'b1} : {part[63:0], 1'b0};

   assign quo  = neg_q ? (~part[31:0] + 32'd1) : part[31:0];
   assign rem  = neg_r ? (~part[64:33] + 32'd1) : part[64:33];
   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               next_state = (opdata2 == 32'd0) ? S_DIVZERO : S_ON;
            end
         end
         S_DIVZERO: next_state = annul ? S_IDLE : S_END;
         S_ON: begin
            if (annul) begin
               next_state = S_IDLE;
            end else if (cnt == 6'd32) begin
               next_state = S_END;
            end
         end
         S_END:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt    <= 6'd0;
         part   <= 65'd0;
         dsor   <= 32'd0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= 64'd0;
         ready  <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cnt <= 6'd0;
                  if (opdata2 != 32'd0) begin
                     part  <= {32'd0, mag1, 1'b0};
                     dsor  <= mag2;
                     neg_q <= signed_div && (opdata1[31] ^ opdata2[31]);
                     neg_r <= signed_div && opdata1[31];
                  end else begin
                     // divide-by-zero completes with a zero quotient and remainder
                     part  <= 65'd0;
                     dsor  <= 32'd0;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                  end
               end
            end
            S_ON: begin
               if (!annul && cnt != 6'd32) begin
                  part <= part_step;
                  cnt  <= cnt + 6'd1;
               end
            end
            S_END: begin
               if (!annul) begin
                  result <= {rem, quo};
                  ready  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
